viterbi_tb_ctrl: RTL

VITERBI_TB_CTRL -- requirements
Module: viterbi_tb_ctrl

---
 rtl/viterbi_tb_ctrl.sv | 177 +++++++++++++++++
 1 files changed

// File: rtl/viterbi_tb_ctrl.sv
// ---------------------------------------------------------------------------
// viterbi_tb_ctrl
//
// Window controller for a Viterbi decoder. The controller runs the windowed
// decode sequence:
//   1. Accept WIN symbol pairs. Each accepted pair strobes the ACS and
//      survivor update.
//   2. Spend one LOAD cycle. During it the traceback unit latches the
//      minimum-metric state and reloads its counter.
//   3. Trace back for WIN cycles. Each decoded bit is collected into a
//      window register.
//   4. Present the window downstream with a valid/ready handshake.
//
// Parameters
//   WIN        traceback window length in symbols (2..8)
//
// Ports
//   clk        sole clock, rising edge
//   rst        asynchronous, active-high reset
//   sym_valid  upstream has a received symbol pair
//   sym_ready  controller accepts a symbol this cycle
//   acs_en     ACS / survivor-register update strobe
//   te         traceback enable
//   oe         traceback output enable
//   tb_cnt     traceback counter returned by the traceback unit
//   d_in       decoded bit from the traceback unit
//   abort      synchronous abandon of the current window
//   dec_data   decoded window, bit 0 = oldest symbol
//   dec_valid  dec_data holds a complete window
//   dec_ready  downstream accepts dec_data
//   busy       high in any state other than ACQ
//   tb_err     sticky traceback-count mismatch flag
// ---------------------------------------------------------------------------
module viterbi_tb_ctrl #(
    parameter int WIN = 8
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           sym_valid,
    output logic           sym_ready,
    output logic           acs_en,
    output logic           te,
    output logic           oe,
    input  logic [3:0]     tb_cnt,
    input  logic           d_in,
    input  logic           abort,
    output logic [WIN-1:0] dec_data,
    output logic           dec_valid,
    input  logic           dec_ready,
    output logic           busy,
    output logic           tb_err
);

    localparam int CNT_W = 3;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIN - 1);
    // After WIN trace steps from a reload value of 8, the traceback unit's
    // counter must read 8-WIN.
    localparam logic [3:0] TB_CNT_EXP = 4'(8 - WIN);

    typedef enum logic [1:0] {
        ACQ   = 2'd0,
        LOAD  = 2'd1,
        TRACE = 2'd2,
        OUT   = 2'd3
    } state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] acq_cnt_q, acq_cnt_d;
    logic [CNT_W-1:0] trace_cnt_q, trace_cnt_d;
    logic [WIN-1:0]   dec_data_q, dec_data_d;
    logic             dec_valid_q, dec_valid_d;
    logic             first_out_q, first_out_d;
    logic             tb_err_q, tb_err_d;

    // Status outputs are decoded straight from the state register. The
    // register clears asynchronously, so te and oe drop the moment rst
    // rises. sym_ready is additionally masked while rst is held, so that
    // nothing is accepted during reset.
    always_comb begin
        sym_ready = (state_q == ACQ) && !rst;
        acs_en    = sym_valid && sym_ready;
        te        = (state_q == TRACE);
        oe        = (state_q == TRACE);
        busy      = (state_q != ACQ);
        dec_data  = dec_data_q;
        dec_valid = dec_valid_q;
        tb_err    = tb_err_q;
    end

    always_comb begin
        state_d     = state_q;
        acq_cnt_d   = acq_cnt_q;
        trace_cnt_d = trace_cnt_q;
        dec_data_d  = dec_data_q;
        dec_valid_d = dec_valid_q;
        first_out_d = 1'b0;
        tb_err_d    = tb_err_q;

        // The traceback count is checked once, in the first OUT cycle. A
        // mismatch is recorded, but the window is still delivered.
        if ((state_q == OUT) && first_out_q && (tb_cnt != TB_CNT_EXP)) begin
            tb_err_d = 1'b1;
        end

        if (abort) begin
            // abort outranks every other transition. dec_data is left as it is.
            state_d     = ACQ;
            acq_cnt_d   = '0;
            trace_cnt_d = '0;
            dec_valid_d = 1'b0;
        end else begin
            case (state_q)
                ACQ: begin
                    if (acs_en) begin
                        if (acq_cnt_q == LAST_CNT) begin
                            acq_cnt_d = '0;
                            state_d   = LOAD;
                        end else begin
                            acq_cnt_d = acq_cnt_q + 1'b1;
                        end
                    end
                end
                LOAD: begin
                    trace_cnt_d = '0;
                    state_d     = TRACE;
                end
                TRACE: begin
                    // Traceback runs newest to oldest. Trace step k fills
                    // bit WIN-1-k, so the last bit traced lands in bit 0.
                    for (int i = 0; i < WIN; i++) begin
                        if (i == (WIN - 1 - int'(trace_cnt_q))) begin
                            dec_data_d[i] = d_in;
                        end
                    end
                    if (trace_cnt_q == LAST_CNT) begin
                        trace_cnt_d = '0;
                        dec_valid_d = 1'b1;
                        first_out_d = 1'b1;
                        state_d     = OUT;
                    end else begin
                        trace_cnt_d = trace_cnt_q + 1'b1;
                    end
                end
                OUT: begin
                    if (dec_valid_q && dec_ready) begin
                        dec_valid_d = 1'b0;
                        state_d     = ACQ;
                    end
                end
                default: begin
                    state_d = ACQ;
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ACQ;
            acq_cnt_q   <= '0;
            trace_cnt_q <= '0;
            dec_data_q  <= '0;
            dec_valid_q <= 1'b0;
            first_out_q <= 1'b0;
            tb_err_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            acq_cnt_q   <= acq_cnt_d;
            trace_cnt_q <= trace_cnt_d;
            dec_data_q  <= dec_data_d;
            dec_valid_q <= dec_valid_d;
            first_out_q <= first_out_d;
            tb_err_q    <= tb_err_d;
        end
    end

endmodule
